// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: loadable instruction store, PC sequencing, valid/ready issue to the core.
// Optional IFU_ECALL_HALT_EN: an accepted ECALL (32'h0000_0073) ends the program in place.
module instr_fetch_unit #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [XLEN-1:0]   branch_target,
  output logic [XLEN-1:0]   pc,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state;
  logic [31:0]     mem [DEPTH];
  logic [ADDR_W:0] prog_len;

  logic            load_ok;
  logic [ADDR_W:0] load_len;
  logic [XLEN-1:0] next_pc;
  logic            misaligned;
  logic            past_end;
  logic            is_ecall;

  assign load_ok    = (state == S_IDLE) || (state == S_DONE) || (state == S_ERROR);
  assign load_len   = {1'b0, load_addr} + (ADDR_W + 1)'(1);
  assign next_pc    = branch_taken ? branch_target : pc + XLEN'(4);
  assign misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  // Full upper word index, so targets wrapping far beyond the store still terminate.
  assign past_end   = next_pc[XLEN-1:2] >= (XLEN - 2)'(prog_len);

`ifdef IFU_ECALL_HALT_EN
  assign is_ecall = (instruction == 32'h0000_0073);
`else
  assign is_ecall = 1'b0;
`endif

  // Store contents survive reset and start.
  always_ff @(posedge clk) begin
    if (load_en && load_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      prog_len    <= '0;
      instruction <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      done        <= 1'b0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      if (load_en && load_ok && (load_len > prog_len)) begin
        prog_len <= load_len;
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          // start sees prog_len from before any load in this same cycle
          if (start) begin
            pc          <= '0;
            instr_count <= '0;
            error       <= 1'b0;
            done        <= (prog_len == '0);
            state       <= (prog_len == '0) ? S_DONE : S_FETCH;
          end
        end

        S_FETCH: begin
          instruction <= mem[pc[ADDR_W+1:2]];
          instr_valid <= 1'b1;
          state       <= S_ISSUE;
        end

        S_ISSUE: begin
          if (instr_ready) begin
            instr_count <= instr_count + (ADDR_W + 1)'(1);
            instr_valid <= 1'b0;
            if (is_ecall) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (misaligned) begin
              error <= 1'b1;
              state <= S_ERROR;
            end else if (past_end) begin
              pc    <= next_pc;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc    <= next_pc;
              state <= S_FETCH;
            end
          end
        end

        default: begin
          instr_valid <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule
